// File: rtl/axi4_lite_slave_write_responder_if.sv
// AXI4-Lite write-channel bundle (AW, W and B) for axi4_lite_slave_write_responder.
//
// Signals:
//   awaddr/awprot/awvalid/awready   write address channel
//   wdata/wstrb/wvalid/wready       write data channel
//   bresp/bvalid/bready             write response channel
// Modports:
//   master - drives AW/W payload and valids, plus bready
//   slave  - drives awready, wready, bresp and bvalid
interface axi4_lite_slave_write_responder_if #(
    parameter int unsigned ADDRESS_WIDTH = 32,
    parameter int unsigned DATA_WIDTH    = 32
);
    logic [ADDRESS_WIDTH-1:0]  awaddr;
    logic [2:0]                awprot;
    logic                      awvalid;
    logic                      awready;
    logic [DATA_WIDTH-1:0]     wdata;
    logic [DATA_WIDTH/8-1:0]   wstrb;
    logic                      wvalid;
    logic                      wready;
    logic [1:0]                bresp;
    logic                      bvalid;
    logic                      bready;

    modport master (
        output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
        input  awready, wready, bresp, bvalid
    );

    modport slave (
        input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
        output awready, wready, bresp, bvalid
    );
endinterface

// File: rtl/axi4_lite_slave_write_responder.sv
// AXI4-Lite write responder: buffers one AW and one W beat, decodes the
// address into a register index, issues a single-cycle register write
// strobe and returns OKAY/SLVERR on the B channel. Invalid addresses
// (misaligned or beyond NUM_REGS words) are answered with SLVERR and
// counted in a saturating 8-bit error counter.
//
// Parameters:
//   ADDRESS_WIDTH  awaddr width
//   DATA_WIDTH     wdata width (32 or 64)
//   NUM_REGS       number of word registers decoded from address 0
// Ports:
//   aclk, areset   clock (rising edge) and asynchronous active-high reset
//   s_axi          slave side of the AW/W/B channels
//   reg_wr_en      one-cycle register write pulse
//   reg_wr_index   target register index
//   reg_wr_data    buffered write data
//   reg_wr_strb    buffered byte strobes
//   err_count      saturating count of SLVERR responses
module axi4_lite_slave_write_responder #(
    parameter int unsigned ADDRESS_WIDTH = 32,
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned NUM_REGS      = 16
) (
    input  logic                          aclk,
    input  logic                          areset,
    axi4_lite_slave_write_responder_if.slave s_axi,
    output logic                          reg_wr_en,
    output logic [$clog2(NUM_REGS)-1:0]   reg_wr_index,
    output logic [DATA_WIDTH-1:0]         reg_wr_data,
    output logic [DATA_WIDTH/8-1:0]       reg_wr_strb,
    output logic [7:0]                    err_count
);

    localparam int unsigned STRB_W   = DATA_WIDTH / 8;
    localparam int unsigned BYTE_LSB = $clog2(STRB_W);
    localparam int unsigned IDX_W    = $clog2(NUM_REGS);
    // One extra bit so the limit cannot wrap when the register window
    // spans the whole address space.
    localparam logic [ADDRESS_WIDTH:0] ADDR_LIMIT = (ADDRESS_WIDTH + 1)'(NUM_REGS * STRB_W);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WRITE,
        ST_RESP
    } state_t;

    state_t                   r_state;

    logic [ADDRESS_WIDTH-1:0] r_aw_addr;
    logic [2:0]               r_aw_prot;
    logic                     r_aw_full;
    logic [DATA_WIDTH-1:0]    r_w_data;
    logic [STRB_W-1:0]        r_w_strb;
    logic                     r_w_full;

    logic                     r_bvalid;
    logic [1:0]               r_bresp;
    logic                     r_reg_wr_en;
    logic [IDX_W-1:0]         r_reg_wr_index;
    logic [DATA_WIDTH-1:0]    r_reg_wr_data;
    logic [STRB_W-1:0]        r_reg_wr_strb;
    logic [7:0]               r_err_count;

    logic                     w_aw_hs;
    logic                     w_w_hs;
    logic                     w_b_hs;
    logic                     w_addr_aligned;
    logic                     w_addr_in_range;
    logic                     w_addr_ok;
    logic                     w_prot_unused;

    // Readies come straight from the buffer flags, so no valid ever
    // reaches a ready combinationally.
    assign s_axi.awready = ~r_aw_full;
    assign s_axi.wready  = ~r_w_full;
    assign s_axi.bvalid  = r_bvalid;
    assign s_axi.bresp   = r_bresp;

    assign reg_wr_en     = r_reg_wr_en;
    assign reg_wr_index  = r_reg_wr_index;
    assign reg_wr_data   = r_reg_wr_data;
    assign reg_wr_strb   = r_reg_wr_strb;
    assign err_count     = r_err_count;

    assign w_aw_hs = s_axi.awvalid & ~r_aw_full;
    assign w_w_hs  = s_axi.wvalid & ~r_w_full;
    // bvalid is high for exactly the RESP state, so this is the B handshake.
    assign w_b_hs  = (r_state == ST_RESP) & s_axi.bready;

    // Decode works on the buffered address, which cannot change while the
    // transaction is in flight because the AW buffer stays full until B.
    assign w_addr_aligned  = (r_aw_addr[BYTE_LSB-1:0] == '0);
    assign w_addr_in_range = ({1'b0, r_aw_addr} < ADDR_LIMIT);
    assign w_addr_ok       = w_addr_aligned & w_addr_in_range;

    // awprot is captured with the address but never decoded.
    assign w_prot_unused = ^r_aw_prot;

    // One-entry AW and W buffers; both drain together on the B handshake.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_aw_addr <= '0;
            r_aw_prot <= '0;
            r_aw_full <= 1'b0;
            r_w_data  <= '0;
            r_w_strb  <= '0;
            r_w_full  <= 1'b0;
        end else if (w_b_hs) begin
            r_aw_full <= 1'b0;
            r_w_full  <= 1'b0;
        end else begin
            if (w_aw_hs) begin
                r_aw_addr <= s_axi.awaddr;
                r_aw_prot <= s_axi.awprot;
                r_aw_full <= 1'b1;
            end
            if (w_w_hs) begin
                r_w_data <= s_axi.wdata;
                r_w_strb <= s_axi.wstrb;
                r_w_full <= 1'b1;
            end
        end
    end

    // Control FSM with registered outputs. The write strobe is set on the
    // IDLE->WRITE edge so it is high during the WRITE cycle; register
    // payload outputs only move for valid addresses so rejected writes
    // leave them untouched.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_state        <= ST_IDLE;
            r_bvalid       <= 1'b0;
            r_bresp        <= RESP_OKAY;
            r_reg_wr_en    <= 1'b0;
            r_reg_wr_index <= '0;
            r_reg_wr_data  <= '0;
            r_reg_wr_strb  <= '0;
            r_err_count    <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (r_aw_full && r_w_full) begin
                        r_state     <= ST_WRITE;
                        r_reg_wr_en <= w_addr_ok;
                        if (w_addr_ok) begin
                            r_reg_wr_index <= r_aw_addr[BYTE_LSB +: IDX_W];
                            r_reg_wr_data  <= r_w_data;
                            r_reg_wr_strb  <= r_w_strb;
                        end
                    end
                end
                ST_WRITE: begin
                    r_state     <= ST_RESP;
                    r_reg_wr_en <= 1'b0;
                    r_bvalid    <= 1'b1;
                    r_bresp     <= w_addr_ok ? RESP_OKAY : RESP_SLVERR;
                    if (!w_addr_ok && (r_err_count != 8'hFF)) begin
                        r_err_count <= r_err_count + 8'd1;
                    end
                end
                ST_RESP: begin
                    if (s_axi.bready) begin
                        r_state  <= ST_IDLE;
                        r_bvalid <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/axi4_lite_slave_write_responder.md
AXI4_LITE_SLAVE_WRITE_RESPONDER -- requirements
Module: axi4_lite_slave_write_responder

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- ADDRESS_WIDTH, 32, awaddr width.
- DATA_WIDTH, 32, wdata width; allowed values are 32 and 64.
- NUM_REGS, 16, number of word-sized registers decoded from address 0.

REQ-002 The module SHALL have one clock and an asynchronous, active-high reset.

REQ-003 Ports SHALL be (name, direction, width, meaning):
- aclk  in  1  clock; all logic on the rising edge.
- areset  in  1  asynchronous, active-high reset.
- awaddr  in  ADDRESS_WIDTH  write address.
- awprot  in  3  protection; stored, not decoded.
- awvalid  in  1  address valid.
- awready  out  1  address buffer empty.
- wdata  in  DATA_WIDTH  write data.
- wstrb  in  DATA_WIDTH/8  byte strobes.
- wvalid  in  1  data valid.
- wready  out  1  data buffer empty.
- bresp  out  2  write response.
- bvalid  out  1  response valid.
- bready  in  1  master accepts response.
- reg_wr_en  out  1  one-cycle register write pulse.
- reg_wr_index  out  $clog2(NUM_REGS)  target register.
- reg_wr_data  out  DATA_WIDTH  buffered wdata.
- reg_wr_strb  out  DATA_WIDTH/8  buffered wstrb.
- err_count  out  8  saturating count of SLVERR responses.

Function
REQ-004 The block SHALL hold a one-entry AW buffer (awaddr, awprot, aw_full) and a one-entry W buffer (wdata, wstrb, w_full).
REQ-005 awready SHALL equal !aw_full, and wready SHALL equal !w_full; both are registered, so there is no combinational path from any valid to any ready.
REQ-006 An AW handshake (awvalid && awready at an edge) SHALL load the AW buffer and set aw_full; a W handshake SHALL likewise load the W buffer and set w_full. The two channels are independent: either order, or both in the same cycle.
REQ-007 The FSM SHALL have three states: IDLE, WRITE and RESP.
REQ-008 IDLE SHALL go to WRITE at the first edge where aw_full && w_full.
REQ-009 WRITE SHALL always go to RESP at the next edge.
REQ-010 RESP SHALL go to IDLE at the edge where bvalid && bready.
REQ-011 Address decode: the address is OK when awaddr is aligned to DATA_WIDTH/8 and awaddr < NUM_REGS*(DATA_WIDTH/8). When OK, reg_wr_index SHALL be awaddr / (DATA_WIDTH/8).
REQ-012 In WRITE, reg_wr_en SHALL be 1 for exactly one cycle if the address is OK, and 0 otherwise. reg_wr_data and reg_wr_strb SHALL present the buffered values.
REQ-013 wstrb = 0 with an OK address SHALL still pulse reg_wr_en, with reg_wr_strb = 0, and respond OKAY.
REQ-014 bresp SHALL be latched on WRITE->RESP: 2'b00 (OKAY) if the address is OK, else 2'b10 (SLVERR). bresp is never 2'b01 or 2'b11.
REQ-015 bvalid SHALL be 1 exactly while in RESP. bvalid and bresp SHALL stay stable until the handshake, regardless of bready.
REQ-016 On the B handshake edge, aw_full and w_full SHALL both clear, so awready and wready are 1 in the next cycle.
REQ-017 Latency: when the later of the AW/W handshakes occurs at edge E0, reg_wr_en SHALL be high in cycle E1-E2 and bvalid SHALL rise at E2. With bready held high, back-to-back throughput is one write per 4 cycles.
REQ-018 A second AW (or W) presented while its buffer is full SHALL stall (ready low) and SHALL NOT overwrite the buffer.
REQ-019 err_count SHALL increment on each WRITE->RESP transition with SLVERR, and SHALL saturate at 255 (no wrap).
REQ-020 Out-of-range or misaligned writes SHALL NOT alter any register-write output other than the reg_wr_en = 0 behaviour of REQ-012.

Reset
REQ-021 While areset is high, the block SHALL asynchronously force: state = IDLE, aw_full = w_full = 0 (awready = wready = 1), bvalid = 0, bresp = 2'b00, reg_wr_en = 0, err_count = 0, and all buffers = 0.
REQ-022 Reset asserted mid-transaction (in WRITE or RESP) SHALL abort the transaction: no reg_wr_en pulse and no response is produced after reset releases.
REQ-023 After reset deasserts, the first handshake SHALL be accepted at the first rising edge.

Verification
REQ-024 AW 0x08 and W 0xDEADBEEF/0xF in the same cycle, bready = 1 -> reg_wr_en pulses with index 2 and data 0xDEADBEEF; bvalid rises 2 cycles after the handshake with bresp = 00.
REQ-025 W first, AW 3 cycles later (0x3C), bready = 1 -> awready stays high and wready is low until B; reg_wr_index = 15; bresp = 00.
REQ-026 AW 0x40 (out of range) and AW 0x06 (misaligned) -> no reg_wr_en; bresp = 10 each time; err_count = 2.
REQ-027 bready held low 5 cycles in RESP -> bvalid and bresp stable for 5 cycles; a second AW/W is stalled; handshake on cycle 6, then awready = wready = 1 on the next cycle.
REQ-028 areset pulsed during RESP -> bvalid drops immediately; after release, no stale response, and a new write completes normally.
REQ-029 256 SLVERR writes -> err_count stays at 255.
